// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the pulse generator slice.
//   - state_e    : FSM state encoding (IDLE, LEAD, HIGH, LOW, DONE)
//   - CNT_W_DEF  : default width of the pulse-count field
//   - LEN_W_DEF  : default width of the high/low length fields
package pulse_gen_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/pulse_gen_if.sv
// pulse_gen_if: request/response bundle of the pulse generator.
//   req_valid, pulse_cnt, high_len, low_len, abort : requester -> generator
//   req_ready, data_out, busy, done                 : generator -> requester
//   modport master : requester side
//   modport slave  : generator side
interface pulse_gen_if #(
  parameter int CNT_W = pulse_gen_pkg::CNT_W_DEF,
  parameter int LEN_W = pulse_gen_pkg::LEN_W_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] pulse_cnt;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic             abort;
  logic             data_out;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, pulse_cnt, high_len, low_len, abort,
    input  req_ready, data_out, busy, done
  );

  modport slave (
    input  req_valid, pulse_cnt, high_len, low_len, abort,
    output req_ready, data_out, busy, done
  );

endinterface

// File: rtl/pulse_gen_timer.sv
// pulse_gen_timer: loadable LEN_W-bit down-counter timing one HIGH or LOW phase.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (highest priority)
//   load     : load load_val (a zero length is loaded as 1)
//   load_val : phase length in cycles
//   en       : count down by one, saturating at zero (no wrap)
//   expire   : current cycle is the last cycle of the phase
module pulse_gen_timer #(
  parameter int LEN_W = pulse_gen_pkg::LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [LEN_W-1:0] count_r;

  // Phase length register: clear, load (0 promoted to 1) or saturating decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= LEN_ZERO;
    end else if (clr) begin
      count_r <= LEN_ZERO;
    end else if (load) begin
      count_r <= (load_val == LEN_ZERO) ? LEN_ONE : load_val;
    end else if (en && (count_r != LEN_ZERO)) begin
      count_r <= count_r - LEN_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // A value of 1 marks the final cycle; 0 is treated the same so a cleared
  // timer can never hold the FSM in a phase.
  assign expire = (count_r <= LEN_ONE);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: emits a burst of pulse_cnt pulses on data_out, each high for
// max(high_len,1) cycles and followed by max(low_len,1) low cycles. Every
// burst starts with one low LEAD cycle and ends with a one-cycle done strobe.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : pulse_gen_if.slave -- request fields in, data_out/busy/done/req_ready out
// All outputs come straight from registers; no input reaches them combinationally.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pulse_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] rem_r;
  logic [LEN_W-1:0] high_len_r;
  logic [LEN_W-1:0] low_len_r;
  logic             data_out_r;
  logic             busy_r;
  logic             done_r;
  logic             req_ready_r;

  logic             accept_s;
  logic             abort_s;
  logic             rem_dec_s;
  logic             tmr_clr_s;
  logic             tmr_load_s;
  logic             tmr_en_s;
  logic [LEN_W-1:0] tmr_val_s;
  logic             tmr_expire_s;

  pulse_gen_timer #(.LEN_W(LEN_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .expire   (tmr_expire_s)
  );

  // Next-state, timer control and remaining-pulse control.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    abort_s     = 1'b0;
    rem_dec_s   = 1'b0;
    tmr_clr_s   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    tmr_val_s   = high_len_r;

    case (state_r)
      ST_IDLE: begin
        // An abort seen in IDLE blocks acceptance but otherwise does nothing.
        if (bus.req_valid && !bus.abort) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LEAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (rem_r == CNT_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_HIGH;
          tmr_load_s  = 1'b1;
          tmr_val_s   = high_len_r;
        end
      end
      ST_HIGH: begin
        if (tmr_expire_s) begin
          state_nxt_s = ST_LOW;
          tmr_load_s  = 1'b1;
          tmr_val_s   = low_len_r;
          rem_dec_s   = 1'b1;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_LOW: begin
        if (tmr_expire_s) begin
          if (rem_r != CNT_ZERO) begin
            state_nxt_s = ST_HIGH;
            tmr_load_s  = 1'b1;
            tmr_val_s   = high_len_r;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Abort overrides everything above once a burst is in progress.
    if (bus.abort && (state_r != ST_IDLE)) begin
      abort_s     = 1'b1;
      state_nxt_s = ST_IDLE;
      rem_dec_s   = 1'b0;
      tmr_clr_s   = 1'b1;
      tmr_load_s  = 1'b0;
      tmr_en_s    = 1'b0;
    end else begin
      abort_s = 1'b0;
    end
  end

  // State register, latched request fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rem_r       <= CNT_ZERO;
      high_len_r  <= LEN_ZERO;
      low_len_r   <= LEN_ZERO;
      data_out_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      // Outputs are decoded from the state being entered, so they line up
      // with state_r in the same cycle without a combinational path.
      data_out_r  <= (state_nxt_s == ST_HIGH);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      req_ready_r <= (state_nxt_s == ST_IDLE);

      if (abort_s) begin
        rem_r      <= CNT_ZERO;
        high_len_r <= LEN_ZERO;
        low_len_r  <= LEN_ZERO;
      end else if (accept_s) begin
        rem_r      <= bus.pulse_cnt;
        high_len_r <= bus.high_len;
        low_len_r  <= bus.low_len;
      end else if (rem_dec_s) begin
        rem_r <= rem_r - CNT_ONE;
      end else begin
        rem_r <= rem_r;
      end
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.req_ready = req_ready_r;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: self-checking bench for pulse_gen. A reference model builds
// the expected data_out trace of a burst from its (count, high, low) triple;
// the bench then steps the DUT cycle by cycle against that trace.
module tb_pulse_gen;

  localparam int CW = 4;
  localparam int LW = 4;

  typedef bit trace_t[$];

  logic  clk = 1'b0;
  logic  rst;
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_fail  = 0;
  string step    = "reset";

  always #5 clk = ~clk;

  pulse_gen_if #(.CNT_W(CW), .LEN_W(LW)) bus_if ();

  pulse_gen #(.CNT_W(CW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic d, input logic b,
                            input logic dn, input logic rdy);
    chk({tag, "_data_out"},  {31'd0, bus_if.data_out},  {31'd0, d});
    chk({tag, "_busy"},      {31'd0, bus_if.busy},      {31'd0, b});
    chk({tag, "_done"},      {31'd0, bus_if.done},      {31'd0, dn});
    chk({tag, "_req_ready"}, {31'd0, bus_if.req_ready}, {31'd0, rdy});
  endtask

  // Reference model: LEAD low cycle, then N x (H high, L low), zero lengths as 1.
  function automatic trace_t model_trace(input int n, input int h, input int l);
    trace_t tr;
    int     he;
    int     le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    tr.push_back(1'b0);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < he; i++) tr.push_back(1'b1);
      for (int i = 0; i < le; i++) tr.push_back(1'b0);
    end
    return tr;
  endfunction

  task automatic scramble_fields();
    bus_if.pulse_cnt = CW'($urandom);
    bus_if.high_len  = LW'($urandom);
    bus_if.low_len   = LW'($urandom);
  endtask

  // Called at a falling edge while IDLE. Issues one request and checks every
  // cycle until the DUT is back in IDLE (or until the abort has taken effect).
  task automatic run_burst(input int n, input int h, input int l, input int abort_at,
                           input bit hold_valid, output int pulses);
    trace_t tr;
    logic   prev;
    tr     = model_trace(n, h, l);
    pulses = 0;
    prev   = 1'b0;
    chk("pre_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
    bus_if.pulse_cnt = CW'(n);
    bus_if.high_len  = LW'(h);
    bus_if.low_len   = LW'(l);
    bus_if.abort     = 1'b0;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Fields change after acceptance; the DUT must keep the latched copy.
    bus_if.req_valid = hold_valid;
    scramble_fields();
    for (int k = 1; k <= tr.size(); k++) begin
      expect_out($sformatf("cyc%0d", k), tr[k-1], 1'b1, 1'b0, 1'b0);
      if ((bus_if.data_out === 1'b1) && (prev === 1'b0)) pulses++;
      prev = bus_if.data_out;
      if (k == abort_at) begin
        bus_if.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.abort = 1'b0;
        expect_out("post_abort", 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    expect_out("done", 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int p;
    int n;
    int h;
    int l;
    int ab;

    rst              = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.abort     = 1'b0;
    bus_if.pulse_cnt = {CW{1'b0}};
    bus_if.high_len  = {LW{1'b0}};
    bus_if.low_len   = {LW{1'b0}};

    #2;
    step = "reset";
    expect_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out("after_release", 1'b0, 1'b0, 1'b0, 1'b1);

    step = "cnt3_h1_l2";
    run_burst(3, 1, 2, 0, 1'b0, p);
    chk("pulses", p, 32'd3);

    step = "cnt0";
    run_burst(0, 5, 5, 0, 1'b0, p);
    chk("pulses", p, 32'd0);

    step = "cnt1_h0_l0";
    run_burst(1, 0, 0, 0, 1'b0, p);
    chk("pulses", p, 32'd1);

    step = "abort_2nd_high";
    run_burst(2, 4, 3, 3, 1'b0, p);

    step = "max_len";
    run_burst(2, 15, 15, 0, 1'b0, p);
    chk("pulses", p, 32'd2);

    step = "back_to_back_1";
    run_burst(2, 2, 1, 0, 1'b1, p);
    chk("pulses", p, 32'd2);
    step = "back_to_back_2";
    run_burst(1, 3, 2, 0, 1'b0, p);
    chk("pulses", p, 32'd1);

    step = "idle_abort";
    bus_if.pulse_cnt = CW'(2);
    bus_if.req_valid = 1'b1;
    bus_if.abort     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_out("blocked", 1'b0, 1'b0, 1'b0, 1'b1);
    bus_if.req_valid = 1'b0;
    bus_if.abort     = 1'b0;

    step = "reset_in_low";
    bus_if.pulse_cnt = CW'(5);
    bus_if.high_len  = LW'(2);
    bus_if.low_len   = LW'(3);
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    expect_out("in_low", 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_burst(1, 1, 1, 0, 1'b0, p);
    chk("pulses", p, 32'd1);

    for (int it = 0; it < 12; it++) begin
      n  = $urandom_range(0, 5);
      h  = $urandom_range(0, 15);
      l  = $urandom_range(0, 15);
      ab = 0;
      if ($urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, model_trace(n, h, l).size());
      end
      step = $sformatf("rand%0d_n%0d_h%0d_l%0d_ab%0d", it, n, h, l, ab);
      run_burst(n, h, l, ab, 1'($urandom_range(0, 1)), p);
      if (ab == 0) chk("pulses", p, n);
    end
    bus_if.req_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
